// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer with FU writeback and CDB broadcast; define ROB_BRANCH_FLUSH_EN to flush younger entries on a taken branch
module reorder_buffer #(
  parameter int WORD_SIZE = 16,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 4,
  parameter int FU_NUM    = 4,
  parameter int REG_INDEX = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic                          alloc_is_branch,
  input  logic [REG_INDEX-1:0]          alloc_dest_reg,
  output logic [RB_INDEX-1:0]           alloc_index,
  output logic                          full,
  output logic [RB_INDEX:0]             count,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          commit_en,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic [RB_INDEX-1:0]           commit_index,
  output logic                          flush
);
  localparam int PW = $clog2(RB_SIZE);
  logic [RB_SIZE-1:0]   busy_q, done_q, br_q, wb_hit;
  logic [REG_INDEX-1:0] dest_q [RB_SIZE];
  logic [WORD_SIZE-1:0] val_q [RB_SIZE];
  logic [WORD_SIZE-1:0] wb_val [RB_SIZE];
  logic [PW-1:0]        head_q, tail_q;
  logic [RB_INDEX:0]    count_q;
  logic                 do_alloc, do_commit;
  logic                 commit_en_q;
  logic [REG_INDEX-1:0] commit_reg_q;
  logic [WORD_SIZE-1:0] commit_data_q;
  logic [RB_INDEX-1:0]  commit_index_q;
  assign full           = count_q == (RB_INDEX+1)'(RB_SIZE);
  assign count          = count_q;
  assign alloc_index    = RB_INDEX'(tail_q);
  assign do_alloc       = alloc_req && !full;
  assign do_commit      = busy_q[head_q] && done_q[head_q];
  assign CDB_data_valid = busy_q & done_q;
  assign commit_en      = commit_en_q;
  assign commit_reg     = commit_reg_q;
  assign commit_data    = commit_data_q;
  assign commit_index   = commit_index_q;
  for (genvar g = 0; g < RB_SIZE; g++) begin : g_cdb
    assign CDB_data_data[g*WORD_SIZE +: WORD_SIZE] = val_q[g];
  end
`ifdef ROB_BRANCH_FLUSH_EN
  logic take, flush_q;
  assign take  = do_commit && br_q[head_q] && val_q[head_q][0];
  assign flush = flush_q;
`else
  assign flush = 1'b0;
`endif
  // per-entry writeback select; scanning slots high to low lets the lowest slot win
  always_comb begin
    for (int i = 0; i < RB_SIZE; i++) begin
      wb_hit[i] = 1'b0;
      wb_val[i] = '0;
      for (int k = FU_NUM - 1; k >= 0; k--)
        if (valid_bus[k] && RB_index_bus[k*RB_INDEX +: RB_INDEX] == RB_INDEX'(i)) begin
          wb_hit[i] = 1'b1;
          wb_val[i] = data_bus[k*WORD_SIZE +: WORD_SIZE];
        end
    end
  end
  // entry state, pointers and registered retirement outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      br_q           <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_reg_q   <= '0;
      commit_data_q  <= '0;
      commit_index_q <= '0;
      for (int i = 0; i < RB_SIZE; i++) begin
        dest_q[i] <= '0;
        val_q[i]  <= '0;
      end
`ifdef ROB_BRANCH_FLUSH_EN
      flush_q        <= 1'b0;
`endif
    end else begin
      commit_en_q <= 1'b0;
      for (int i = 0; i < RB_SIZE; i++)
        if (wb_hit[i] && busy_q[i] && !done_q[i]) begin
          done_q[i] <= 1'b1;
          val_q[i]  <= wb_val[i];
        end
      if (do_alloc) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        br_q[tail_q]   <= alloc_is_branch;
        dest_q[tail_q] <= alloc_dest_reg;
        val_q[tail_q]  <= '0;
        tail_q         <= tail_q + PW'(1);
      end
      if (do_commit) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        val_q[head_q]  <= '0;
        head_q         <= head_q + PW'(1);
        commit_en_q    <= !br_q[head_q];
        commit_reg_q   <= dest_q[head_q];
        commit_data_q  <= val_q[head_q];
        commit_index_q <= RB_INDEX'(head_q);
      end
      count_q <= count_q + (RB_INDEX+1)'(do_alloc) - (RB_INDEX+1)'(do_commit);
`ifdef ROB_BRANCH_FLUSH_EN
      flush_q <= take;
      if (take) begin
        busy_q  <= '0;
        done_q  <= '0;
        tail_q  <= head_q + PW'(1);
        count_q <= '0;
        for (int i = 0; i < RB_SIZE; i++) val_q[i] <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic checked against a queue-based model
module tb_reorder_buffer;
  localparam int WS = 16, RS = 8, RI = 4, FN = 4, RG = 5;
`ifdef ROB_BRANCH_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic alloc_req = 1'b0, alloc_is_branch = 1'b0;
  logic [RG-1:0] alloc_dest_reg = '0;
  logic [RI-1:0] alloc_index;
  logic full;
  logic [RI:0] count;
  logic [FN*WS-1:0] data_bus = '0;
  logic [FN-1:0] valid_bus = '0;
  logic [FN*RI-1:0] RB_index_bus = '0;
  logic [WS*RS-1:0] CDB_data_data;
  logic [RS-1:0] CDB_data_valid;
  logic commit_en, flush;
  logic [RG-1:0] commit_reg;
  logic [WS-1:0] commit_data;
  logic [RI-1:0] commit_index;
  int n_vec = 0, n_err = 0;

  reorder_buffer #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .FU_NUM(FN), .REG_INDEX(RG)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_is_branch(alloc_is_branch),
    .alloc_dest_reg(alloc_dest_reg), .alloc_index(alloc_index), .full(full), .count(count),
    .data_bus(data_bus), .valid_bus(valid_bus), .RB_index_bus(RB_index_bus),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid), .commit_en(commit_en),
    .commit_reg(commit_reg), .commit_data(commit_data), .commit_index(commit_index), .flush(flush));

  always #5 clk = ~clk;

  // reference model: in-flight instructions in program order
  typedef struct packed {
    logic [RI-1:0] idx;
    logic [RG-1:0] dest;
    logic          br;
    logic          done;
    logic [WS-1:0] val;
  } ent_t;
  ent_t q[$];
  int m_tail;
  logic exp_committed, exp_commit_en, exp_flush;
  logic [RG-1:0] exp_commit_reg;
  logic [WS-1:0] exp_commit_data;
  logic [RI-1:0] exp_commit_index;

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    exp_committed = 0; exp_commit_en = 0; exp_flush = 0;
  endtask

  task automatic model_edge();
    bit dc, tk, da, hit;
    ent_t e;
    dc = q.size() > 0 && q[0].done;
    tk = dc && q[0].br && q[0].val[0] && FLUSH;
    da = alloc_req && q.size() < RS;
    for (int j = 0; j < q.size(); j++) begin
      hit = 0;
      for (int k = 0; k < FN; k++)
        if (!hit && !q[j].done && valid_bus[k] && RB_index_bus[k*RI +: RI] == q[j].idx) begin
          hit = 1;
          q[j].done = 1;
          q[j].val = data_bus[k*WS +: WS];
        end
    end
    exp_committed = 0; exp_commit_en = 0; exp_flush = 0;
    e = '0;
    if (dc) begin
      e = q.pop_front();
      exp_committed = 1;
      exp_commit_en = !e.br;
      exp_commit_reg = e.dest;
      exp_commit_data = e.val;
      exp_commit_index = e.idx;
    end
    if (tk) begin
      q.delete();
      exp_flush = 1;
      m_tail = (int'(e.idx) + 1) % RS;
    end else if (da) begin
      q.push_back('{idx: RI'(m_tail), dest: alloc_dest_reg, br: alloc_is_branch, done: 1'b0, val: '0});
      m_tail = (m_tail + 1) % RS;
    end
  endtask

  task automatic cyc(input bit a, input bit br, input logic [RG-1:0] d,
                     input logic [FN-1:0] v, input logic [FN*RI-1:0] ix, input logic [FN*WS-1:0] dt);
    alloc_req = a; alloc_is_branch = br; alloc_dest_reg = d;
    valid_bus = v; RB_index_bus = ix; data_bus = dt;
    model_edge();
    @(posedge clk); #1;
    alloc_req = 0; alloc_is_branch = 0; valid_bus = '0;
  endtask

  task automatic do_reset();
    reset = 1; alloc_req = 0; valid_bus = '0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (CDB_data_valid !== '0 || CDB_data_data !== '0) begin n_err++; $display("FAIL reset_cdb: valid=%h data=%h required 0", CDB_data_valid, CDB_data_data); end
    n_vec++; if ({commit_en, commit_reg, commit_data, commit_index, flush} !== '0) begin n_err++; $display("FAIL reset_commit: en=%b reg=%h data=%h idx=%h flush=%b required 0", commit_en, commit_reg, commit_data, commit_index, flush); end
    n_vec++; if ({full, alloc_index, count} !== '0) begin n_err++; $display("FAIL reset_ptr: full=%b alloc_index=%0d count=%0d required 0", full, alloc_index, count); end
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 0, RG'(i), '0, '0, '0);
    cyc(0, 0, 0, 4'b0111, {4'hF, 4'd1, 4'd0, 4'd2}, {16'd0, 16'd6, 16'd5, 16'd7});
    n_vec++; if (CDB_data_valid !== 8'h07 || CDB_data_data[47:0] !== {16'd7, 16'd6, 16'd5}) begin n_err++; $display("FAIL order_cdb: valid=%h data=%h required 07 0007_0006_0005", CDB_data_valid, CDB_data_data[47:0]); end
    n_vec++; if (commit_en !== 1'b0) begin n_err++; $display("FAIL order_early: commit_en=%b required 0", commit_en); end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, '0, '0, '0);
      n_vec++; if ({commit_en, commit_reg, commit_data} !== {1'b1, RG'(i), WS'(i + 4)}) begin n_err++; $display("FAIL order_commit%0d: en=%b reg=%0d data=%0d required 1 %0d %0d", i, commit_en, commit_reg, commit_data, i, i + 4); end
    end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL order_count: count=%0d required 0", count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < RS; i++) cyc(1, 0, RG'(i + 8), '0, '0, '0);
    n_vec++; if (full !== 1'b1 || count !== 5'(RS)) begin n_err++; $display("FAIL full_set: full=%b count=%0d required 1 %0d", full, count, RS); end
    cyc(1, 0, 5'd31, '0, '0, '0);
    n_vec++; if (count !== 5'(RS) || alloc_index !== 4'd0) begin n_err++; $display("FAIL full_drop: count=%0d alloc_index=%0d required %0d 0", count, alloc_index, RS); end
    cyc(0, 0, 0, 4'b0001, {4'hF, 4'hF, 4'hF, 4'd0}, 64'd9);
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL full_wb: full=%b required 1", full); end
    cyc(0, 0, 0, '0, '0, '0);
    n_vec++; if (full !== 1'b0 || count !== 5'(RS - 1) || commit_en !== 1'b1 || commit_reg !== 5'd8 || commit_data !== 16'd9) begin n_err++; $display("FAIL full_commit: full=%b count=%0d en=%b reg=%0d data=%0d required 0 %0d 1 8 9", full, count, commit_en, commit_reg, commit_data, RS - 1); end
    n_vec++; if (alloc_index !== 4'd0) begin n_err++; $display("FAIL wrap_index: alloc_index=%0d required 0", alloc_index); end
    cyc(1, 0, 5'd20, '0, '0, '0);
    n_vec++; if (full !== 1'b1 || alloc_index !== 4'd1) begin n_err++; $display("FAIL wrap_alloc: full=%b alloc_index=%0d required 1 1", full, alloc_index); end
  endtask

  task automatic test_same_entry();
    do_reset();
    cyc(1, 0, 5'd1, '0, '0, '0);
    cyc(1, 0, 5'd2, '0, '0, '0);
    cyc(0, 0, 0, 4'b0111, {4'hF, 4'd1, 4'hF, 4'd1}, {16'd0, 16'd22, 16'd33, 16'd11});
    n_vec++; if (CDB_data_valid !== 8'h02 || CDB_data_data[31:16] !== 16'd11) begin n_err++; $display("FAIL lowest_slot: valid=%h e1=%0d required 02 11", CDB_data_valid, CDB_data_data[31:16]); end
    cyc(0, 0, 0, 4'b0011, {4'hF, 4'hF, 4'hE, 4'hF}, {16'd0, 16'd0, 16'd44, 16'd55});
    n_vec++; if (CDB_data_valid !== 8'h02 || CDB_data_data[15:0] !== 16'd0 || count !== 5'd2) begin n_err++; $display("FAIL null_idx: valid=%h e0=%0d count=%0d required 02 0 2", CDB_data_valid, CDB_data_data[15:0], count); end
  endtask

  task automatic test_head_latency();
    do_reset();
    cyc(1, 0, 5'd7, '0, '0, '0);
    cyc(0, 0, 0, 4'b0100, {4'hF, 4'd0, 4'hF, 4'hF}, {16'd0, 16'h1234, 32'd0});
    n_vec++; if (CDB_data_valid[0] !== 1'b1 || commit_en !== 1'b0) begin n_err++; $display("FAIL head_wb: valid0=%b commit_en=%b required 1 0", CDB_data_valid[0], commit_en); end
    cyc(0, 0, 0, '0, '0, '0);
    n_vec++; if (commit_en !== 1'b1 || commit_data !== 16'h1234 || commit_reg !== 5'd7 || commit_index !== 4'd0 || CDB_data_valid !== '0) begin n_err++; $display("FAIL head_commit: en=%b data=%h reg=%0d idx=%0d valid=%h required 1 1234 7 0 00", commit_en, commit_data, commit_reg, commit_index, CDB_data_valid); end
  endtask

  task automatic test_branch();
    int nf = 0, nc = 0;
    do_reset();
    cyc(1, 1, 5'd0, '0, '0, '0);
    cyc(1, 0, 5'd4, '0, '0, '0);
    cyc(1, 0, 5'd5, '0, '0, '0);
    cyc(0, 0, 0, 4'b0111, {4'hF, 4'd2, 4'd1, 4'd0}, {16'd0, 16'd50, 16'd40, 16'd1});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, '0, '0, '0);
      nf += int'(flush);
      nc += int'(commit_en);
    end
    n_vec++; if (nf !== int'(FLUSH) || nc !== (FLUSH ? 0 : 2)) begin n_err++; $display("FAIL branch_retire: flushes=%0d commits=%0d required %0d %0d", nf, nc, FLUSH, FLUSH ? 0 : 2); end
    n_vec++; if (count !== '0 || CDB_data_valid !== '0 || alloc_index !== (FLUSH ? 4'd1 : 4'd3)) begin n_err++; $display("FAIL branch_state: count=%0d valid=%h alloc_index=%0d required 0 00 %0d", count, CDB_data_valid, alloc_index, FLUSH ? 1 : 3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, RG'(i + 1), '0, '0, '0);
    cyc(0, 0, 0, 4'b0001, {4'hF, 4'hF, 4'hF, 4'd1}, 64'hAB);
    do_reset();
    n_vec++; if ({CDB_data_valid, CDB_data_data, count, full, alloc_index} !== '0) begin n_err++; $display("FAIL midreset_state: valid=%h count=%0d alloc_index=%0d required 0", CDB_data_valid, count, alloc_index); end
    n_vec++; if ({commit_en, commit_reg, commit_data, commit_index, flush} !== '0) begin n_err++; $display("FAIL midreset_commit: en=%b reg=%h data=%h idx=%h flush=%b required 0", commit_en, commit_reg, commit_data, commit_index, flush); end
  endtask

  task automatic test_random();
    logic [FN-1:0] v;
    logic [FN*RI-1:0] ix;
    logic [FN*WS-1:0] dt;
    logic [RS-1:0] ev;
    logic [WS*RS-1:0] ed;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < FN; k++) begin
        v[k] = $urandom_range(0, 2) == 0;
        ix[k*RI +: RI] = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].idx : RI'($urandom_range(0, 15));
        dt[k*WS +: WS] = WS'($urandom);
      end
      n_vec++; if (full !== (q.size() == RS) || alloc_index !== RI'(m_tail)) begin n_err++; $display("FAIL rnd_pre c%0d: full=%b alloc_index=%0d required %0d %0d", c, full, alloc_index, q.size() == RS, m_tail); end
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, RG'($urandom), v, ix, dt);
      ev = '0; ed = '0;
      foreach (q[j]) begin
        ev[q[j].idx] = q[j].done;
        ed[q[j].idx*WS +: WS] = q[j].val;
      end
      n_vec++; if (count !== 5'(q.size()) || CDB_data_valid !== ev || CDB_data_data !== ed) begin n_err++; $display("FAIL rnd_state c%0d: count=%0d valid=%h required %0d %h data=%h required %h", c, count, CDB_data_valid, q.size(), ev, CDB_data_data, ed); end
      n_vec++; if (commit_en !== exp_commit_en || flush !== exp_flush) begin n_err++; $display("FAIL rnd_pulse c%0d: en=%b flush=%b required %b %b", c, commit_en, flush, exp_commit_en, exp_flush); end
      if (exp_commit_en) begin
        n_vec++; if (commit_reg !== exp_commit_reg || commit_data !== exp_commit_data) begin n_err++; $display("FAIL rnd_commit c%0d: reg=%0d data=%h required %0d %h", c, commit_reg, commit_data, exp_commit_reg, exp_commit_data); end
      end
      if (exp_committed) begin
        n_vec++; if (commit_index !== exp_commit_index) begin n_err++; $display("FAIL rnd_index c%0d: idx=%0d required %0d", c, commit_index, exp_commit_index); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_same_entry();
    test_head_latency();
    test_branch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer (RB) at the consuming end of the functional-unit result interface. Each cycle it collects results that the reservation stations drive on `data_bus`/`valid_bus`/`RB_index_bus`, and republishes completed entries on `CDB_data_data`/`CDB_data_valid` so waiting stations can capture operands. It allocates entries in program order for the issue stage and retires them in order to the register file. A taken branch optionally flushes younger entries.

## Interface
Parameters come from `parameters.v`:
- `WORD_SIZE`, from parameters.v: data word width.
- `RB_SIZE`, from parameters.v: number of entries (power of two).
- `RB_INDEX`, from parameters.v: index width. Also encodes the out-of-range sentinels `NULL` and `READY`.
- `FU_NUM`, from parameters.v: number of functional-unit result slots.
- `REG_INDEX`, from parameters.v: architectural register number width.

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `alloc_req`  in  1  issue requests one entry this cycle.
- `alloc_is_branch`  in  1  entry being allocated is a branch (BGE).
- `alloc_dest_reg`  in  REG_INDEX  destination register of the allocated instruction.
- `alloc_index`  out  RB_INDEX  combinational; equals the tail pointer, i.e. the index the entry will receive.
- `full`  out  1  combinational; count == RB_SIZE.
- `count`  out  RB_INDEX+1  occupied entries.
- `data_bus`  in  FU_NUM*WORD_SIZE  FU result words; slot k is bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE].
- `valid_bus`  in  FU_NUM  slot k result valid.
- `RB_index_bus`  in  FU_NUM*RB_INDEX  slot k destination entry.
- `CDB_data_data`  out  WORD_SIZE*RB_SIZE  value held by each entry.
- `CDB_data_valid`  out  RB_SIZE  bit i = entry i busy and done.
- `commit_en`  out  1  one-cycle pulse that writes `commit_data` to `commit_reg`.
- `commit_reg`  out  REG_INDEX  register number being retired.
- `commit_data`  out  WORD_SIZE  value being retired.
- `commit_index`  out  RB_INDEX  entry index being retired.
- `flush`  out  1  one-cycle pulse when a taken branch retires.

## Operation
Per-entry state: busy, done, is_branch, dest_reg, value. Pointers: head, tail (mod RB_SIZE), count.

- **Allocate:** at an edge with `alloc_req && !full`:
  - set entry[tail] to busy=1, done=0, value=0;
  - latch dest_reg and is_branch;
  - tail+1.
  - An `alloc_req` while `full` is dropped silently. Issue must hold the request.
- **Writeback:** at each edge, for every slot k with `valid_bus[k]`=1:
  - if the slot's index i is a busy, not-done entry, store value=data slot k and set done=1;
  - ignore a slot whose index is `NULL`, `READY`, ≥RB_SIZE, not busy, or already done;
  - if two slots target the same i in one cycle, the lowest k wins.
- **Broadcast:** `CDB_data_data[i]` = entry i value and `CDB_data_valid[i]` = busy&done. Both hold until the entry is freed. Value is cleared to 0 on free.
- **Commit:** at most one per edge. If entry[head] is busy&done:
  - free the entry and advance head+1;
  - drive `commit_index`=head for one cycle;
  - for a non-branch entry: `commit_en`=1, with `commit_reg`/`commit_data` from the entry;
  - for a branch entry: `commit_en`=0, and value bit0 (Vj>=Vk) is the taken flag.
- **count:** updates by +alloc −commit. Allocate and commit in the same cycle leaves count unchanged.
- **Simultaneous events:**
  - Writeback of the head entry at edge N retires at edge N+1, not N.
  - `full` is evaluated before the edge, so a full buffer refuses allocation even if it commits in the same cycle.
- **Reset mid-operation:** drops all entries.

## Timing
- Reset values: head=tail=count=0, all entries clear, `CDB_data_valid`=0, `CDB_data_data`=0, `commit_en`=0, `commit_reg`=0, `commit_data`=0, `commit_index`=0, `flush`=0, `full`=0, `alloc_index`=0.
- Allocate at edge N: `CDB_data_valid[i]`=0 from N. The entry can complete at edge N+1 at the earliest.
- Writeback at edge N: `CDB_data_valid[i]`=1 after N.
- If that entry is the head, commit occurs at N+1 and `commit_en` is high for the cycle following N+1.
- Steady-state throughput: one allocation and one retirement per cycle.
- Pointer wrap: index RB_SIZE-1 is followed by 0.

## Configuration
- `ROB_BRANCH_FLUSH_EN` defined: retiring a branch whose value bit0=1 does the following at that edge:
  - pulses `flush` for one cycle;
  - frees every entry, setting all `CDB_data_valid`=0;
  - sets tail=head+1 (the new head) and count=0;
  - discards any allocation or writeback in the same cycle.
- Branch retirement with bit0=0 behaves as a normal commit with no flush.
- Undefined: `flush` is tied 0 and branches retire without flushing.

## Test plan
- Reset, allocate 3 entries (r1, r2, r3), write back entries 2, 0, 1 with values 7, 5, 6 on different FU slots → commits in order: r1=5, r2=6, r3=7 on consecutive cycles; `count` returns to 0.
- Allocate RB_SIZE entries → `full`=1 and a further `alloc_req` is ignored. Complete and commit entry 0 → `full` drops. Allocating gives `alloc_index`=0 (wrap).
- Two FU slots (k=0 and k=2) target entry 1 with 11 and 22 in the same cycle → entry 1 value=11. Also assert `valid_bus` with index=`NULL` → no state change.
- Writeback of head entry with 0x1234 at edge N → `CDB_data_valid[0]`=1 after N, `commit_en`=1 with `commit_data`=0x1234 after N+1.
- With `ROB_BRANCH_FLUSH_EN`: entries = branch (result 1) + 2 younger done entries → `flush` pulses, no `commit_en` for the younger entries, `count`=0. Without the macro → all three retire and `flush` stays 0.
- Assert `reset` with 4 busy entries → the next cycle shows all outputs at their reset values.
